// File: rtl/chess_clock_top.sv
// Two-player chess clock core with an 8-digit multiplexed 7-segment driver.
// Player A owns digits 7..4 (MM:SS), player B owns digits 3..0 (MM:SS).
// Optional build macro TIMEOUT_LOCK_EN: once either player reaches 00:00
// while running, all countdown and set actions freeze until CLR.
module chess_clock_top #(
  parameter int INIT_MIN = 5,
  parameter int SCAN_DIV = 1
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       CE,
  input  logic       SELECT,
  input  logic       STOP,
  input  logic       Set_Impulse,
  input  logic       D1,
  input  logic       D2,
  input  logic       D3,
  input  logic       D4,
  input  logic       D5,
  input  logic       D6,
  input  logic       D7,
  input  logic       D8,
  output logic [6:0] seg_out,
  output logic [7:0] seg_select
);

  localparam logic [3:0] INIT_MT = 4'(INIT_MIN / 10);
  localparam logic [3:0] INIT_MU = 4'(INIT_MIN % 10);
  localparam logic [15:0] INIT_TIME = {INIT_MT, INIT_MU, 8'h00};
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // Time words are packed {min tens, min units, sec tens, sec units}, BCD.
  logic [15:0]   time_a;
  logic [15:0]   time_b;
  logic          set_q;
  logic          set_rise;
  logic          frozen;
  logic          any_zero;
  logic [PW-1:0] presc;
  logic [2:0]    scan_idx;
  logic [3:0]    cur_digit;

  // One-second decrement with borrow chain; saturates at 00:00.
  function automatic logic [15:0] dec_sat(input logic [15:0] t);
    logic [3:0] mt, mu, st, su;
    {mt, mu, st, su} = t;
    if (t != 16'h0000) begin
      if (su != 4'd0) begin
        su = su - 4'd1;
      end else begin
        su = 4'd9;
        if (st != 4'd0) begin
          st = st - 4'd1;
        end else begin
          st = 4'd5;
          if (mu != 4'd0) begin
            mu = mu - 4'd1;
          end else begin
            mu = 4'd9;
            mt = mt - 4'd1;
          end
        end
      end
    end
    return {mt, mu, st, su};
  endfunction

  // Single-digit increment wrapping at the digit's maximum value.
  function automatic logic [3:0] inc_wrap(input logic [3:0] d, input logic [3:0] max_val);
    return (d >= max_val) ? 4'd0 : d + 4'd1;
  endfunction

  // Increments each digit whose mask bit is set; no carry between digits.
  function automatic logic [15:0] set_inc(input logic [15:0] t, input logic [3:0] mask);
    logic [3:0] mt, mu, st, su;
    {mt, mu, st, su} = t;
    if (mask[3]) mt = inc_wrap(mt, 4'd9);
    if (mask[2]) mu = inc_wrap(mu, 4'd9);
    if (mask[1]) st = inc_wrap(st, 4'd5);
    if (mask[0]) su = inc_wrap(su, 4'd9);
    return {mt, mu, st, su};
  endfunction

  // BCD digit to active-low segments, bit6 = g .. bit0 = a.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign set_rise = Set_Impulse & ~set_q;
  assign any_zero = (time_a == 16'h0000) || (time_b == 16'h0000);

`ifdef TIMEOUT_LOCK_EN
  logic lock_q;

  // Latch the timeout once a player expires while the clock is running.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      lock_q <= 1'b0;
    end else if (!STOP && any_zero) begin
      lock_q <= 1'b1;
    end
  end

  assign frozen = lock_q | (~STOP & any_zero);
`else
  assign frozen = 1'b0;
`endif

  // Edge register for the set strobe; tracks regardless of STOP.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      set_q <= 1'b0;
    end else begin
      set_q <= Set_Impulse;
    end
  end

  // Player times: countdown for the selected player, or digit setting when stopped.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      time_a <= INIT_TIME;
      time_b <= INIT_TIME;
    end else if (!frozen) begin
      if (!STOP && CE) begin
        if (SELECT) begin
          time_b <= dec_sat(time_b);
        end else begin
          time_a <= dec_sat(time_a);
        end
      end else if (STOP && set_rise) begin
        time_a <= set_inc(time_a, {D1, D2, D3, D4});
        time_b <= set_inc(time_b, {D5, D6, D7, D8});
      end
    end
  end

  // Display scan: prescaler steps the digit index every SCAN_DIV cycles.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      presc    <= '0;
      scan_idx <= 3'd0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc    <= '0;
      scan_idx <= scan_idx + 3'd1;
    end else begin
      presc    <= presc + PW'(1);
    end
  end

  // Select the digit under the scan index and drive the active-low outputs.
  always_comb begin
    cur_digit = 4'd0;
    case (scan_idx)
      3'd7:    cur_digit = time_a[15:12];
      3'd6:    cur_digit = time_a[11:8];
      3'd5:    cur_digit = time_a[7:4];
      3'd4:    cur_digit = time_a[3:0];
      3'd3:    cur_digit = time_b[15:12];
      3'd2:    cur_digit = time_b[11:8];
      3'd1:    cur_digit = time_b[7:4];
      default: cur_digit = time_b[3:0];
    endcase
    seg_out    = seg_decode(cur_digit);
    seg_select = ~(8'b00000001 << scan_idx);
  end

endmodule

// File: tb/tb_chess_clock_top.sv
// Self-checking bench for chess_clock_top (INIT_MIN=5, SCAN_DIV=1).
// Player times are recovered by scanning all eight display digits.
module tb_chess_clock_top;

  logic       CLK = 1'b0;
  logic       CLR, CE, SELECT, STOP, Set_Impulse;
  logic [7:0] d;
  logic [6:0] seg_out;
  logic [7:0] seg_select;

  int tests = 0;
  int fails = 0;

  logic [31:0] sb_q[$];

  typedef struct {
    logic        ce;
    logic        sel;
    logic        stop;
    logic        set;
    logic        tog;
    logic [7:0]  d;
    int          n;
    logic [15:0] ea;
    logic [15:0] eb;
  } vec_t;

  vec_t vecs[10];

  chess_clock_top #(.INIT_MIN(5), .SCAN_DIV(1)) dut (
    .CLK(CLK), .CLR(CLR), .CE(CE), .SELECT(SELECT), .STOP(STOP),
    .Set_Impulse(Set_Impulse),
    .D1(d[0]), .D2(d[1]), .D3(d[2]), .D4(d[3]),
    .D5(d[4]), .D6(d[5]), .D7(d[6]), .D8(d[7]),
    .seg_out(seg_out), .seg_select(seg_select)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (tests=%0d)", tests);
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] seg2dig(input logic [6:0] s);
    case (s)
      7'b1000000: return 4'd0;
      7'b1111001: return 4'd1;
      7'b0100100: return 4'd2;
      7'b0110000: return 4'd3;
      7'b0011001: return 4'd4;
      7'b0010010: return 4'd5;
      7'b0000010: return 4'd6;
      7'b1111000: return 4'd7;
      7'b0000000: return 4'd8;
      7'b0010000: return 4'd9;
      default:    return 4'hF;
    endcase
  endfunction

  // Drive one vector for n edges, then queue the expected player times.
  task automatic apply(input vec_t v);
    for (int c = 0; c < v.n; c++) begin
      CE          = v.ce;
      SELECT      = v.sel;
      STOP        = v.stop;
      Set_Impulse = v.tog ? ((c % 2) == 0) : v.set;
      d           = v.d;
      tick();
    end
    CE = 1'b0;
    sb_q.push_back({v.ea, v.eb});
  endtask

  // Walk eight scan steps, rebuild both times, compare against the queue head.
  task automatic read_display(input string name);
    logic [3:0]  dig[8];
    logic [31:0] exp;
    int          prev;
    int          idx;
    logic        order_ok;
    order_ok = 1'b1;
    prev     = -1;
    for (int k = 0; k < 8; k++) dig[k] = 4'hF;
    for (int c = 0; c < 8; c++) begin
      idx = -1;
      for (int k = 0; k < 8; k++) if (seg_select[k] == 1'b0) idx = k;
      if (!$onehot(~seg_select) || idx < 0) begin
        order_ok = 1'b0;
      end else begin
        if (prev >= 0 && idx != ((prev + 1) % 8)) order_ok = 1'b0;
        dig[idx] = seg2dig(seg_out);
        prev     = idx;
      end
      tick();
    end
    check({name, "_scan"}, {31'd0, order_ok}, 32'd1);
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s_queue: got empty scoreboard, expected one entry", name);
    end else begin
      exp = sb_q.pop_front();
      check({name, "_A"}, {16'd0, dig[7], dig[6], dig[5], dig[4]}, {16'd0, exp[31:16]});
      check({name, "_B"}, {16'd0, dig[3], dig[2], dig[1], dig[0]}, {16'd0, exp[15:0]});
    end
  endtask

  initial begin
    vec_t hv;

    vecs[0] = '{ce:1'b1, sel:1'b0, stop:1'b0, set:1'b0, tog:1'b0, d:8'h00, n:1,  ea:16'h0459, eb:16'h0500};
    vecs[1] = '{ce:1'b1, sel:1'b0, stop:1'b0, set:1'b0, tog:1'b0, d:8'h00, n:9,  ea:16'h0450, eb:16'h0500};
    vecs[2] = '{ce:1'b1, sel:1'b0, stop:1'b1, set:1'b1, tog:1'b0, d:8'hFF, n:3,  ea:16'h1501, eb:16'h1611};
    vecs[3] = '{ce:1'b0, sel:1'b0, stop:1'b1, set:1'b0, tog:1'b0, d:8'hFF, n:1,  ea:16'h1501, eb:16'h1611};
    vecs[4] = '{ce:1'b0, sel:1'b0, stop:1'b1, set:1'b0, tog:1'b1, d:8'h10, n:18, ea:16'h1501, eb:16'h0611};
    vecs[5] = '{ce:1'b0, sel:1'b0, stop:1'b1, set:1'b0, tog:1'b1, d:8'h60, n:8,  ea:16'h1501, eb:16'h0051};
    vecs[6] = '{ce:1'b0, sel:1'b0, stop:1'b1, set:1'b0, tog:1'b1, d:8'hC0, n:2,  ea:16'h1501, eb:16'h0002};
    vecs[7] = '{ce:1'b1, sel:1'b1, stop:1'b0, set:1'b0, tog:1'b0, d:8'h00, n:5,  ea:16'h1501, eb:16'h0000};
    vecs[8] = '{ce:1'b1, sel:1'b0, stop:1'b0, set:1'b0, tog:1'b0, d:8'h00, n:2,  ea:16'h1459, eb:16'h0000};
    vecs[9] = '{ce:1'b0, sel:1'b0, stop:1'b0, set:1'b0, tog:1'b1, d:8'hFF, n:4,  ea:16'h1459, eb:16'h0000};

    CLR = 1'b1; CE = 1'b0; SELECT = 1'b0; STOP = 1'b0; Set_Impulse = 1'b0; d = 8'h00;

    // Reset for two cycles, then check the first two scan positions.
    tick();
    tick();
    CLR = 1'b0;
    check("rst_sel0", {24'd0, seg_select}, 32'h0000_00FE);
    check("rst_seg0", {25'd0, seg_out}, 32'h0000_0040);
    tick();
    check("rst_sel1", {24'd0, seg_select}, 32'h0000_00FD);
    check("rst_seg1", {25'd0, seg_out}, 32'h0000_0040);
    sb_q.push_back({16'h0500, 16'h0500});
    read_display("reset");

    for (int i = 0; i < 10; i++) begin
      apply(vecs[i]);
      read_display($sformatf("v%0d", i));
    end

    // Reset while stopped and counting enabled: times and scan index return.
    STOP = 1'b1;
    CE   = 1'b1;
    tick();
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    CE  = 1'b0;
    check("midclr_sel", {24'd0, seg_select}, 32'h0000_00FE);
    check("midclr_seg", {25'd0, seg_out}, 32'h0000_0040);
    sb_q.push_back({16'h0500, 16'h0500});
    read_display("midclr");

    // Player switching from 05:00 / 05:00.
    hv = '{ce:1'b1, sel:1'b1, stop:1'b0, set:1'b0, tog:1'b0, d:8'h00, n:4, ea:16'h0500, eb:16'h0456};
    apply(hv);
    read_display("switch_b");
    hv = '{ce:1'b1, sel:1'b0, stop:1'b0, set:1'b0, tog:1'b0, d:8'h00, n:2, ea:16'h0458, eb:16'h0456};
    apply(hv);
    read_display("switch_a");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
